// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax over NUM_CLASSES signed scores per frame.
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous abort of the frame in progress
//   in_valid/in_ready/in_data      score stream, class index = arrival order
//   out_valid/out_ready            result handshake, result held until taken
//   out_class/out_max/out_margin   winner index, winner score, max minus runner-up
module argmax_stream #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 18,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_class,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W:0]   out_margin
);
    typedef enum logic {COLLECT, HOLD} state_t;
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d, cls_q, cls_d, out_class_q, out_class_d, cls_n;
    logic signed [DATA_W-1:0]  max_q, max_d, second_q, second_d, max_n, second_n, in_s;
    logic [DATA_W-1:0]         out_max_q, out_max_d;
    logic [DATA_W:0]           out_margin_q, out_margin_d;
    assign in_s       = $signed(in_data);
    assign in_ready   = state_q == COLLECT;
    assign out_valid  = state_q == HOLD;
    assign out_class  = out_class_q;
    assign out_max    = out_max_q;
    assign out_margin = out_margin_q;
    // Running max/second updated with the incoming beat; strict compares keep the lowest index on ties.
    always_comb begin
        max_n    = max_q;
        second_n = second_q;
        cls_n    = cls_q;
        if (cnt_q == '0) begin
            max_n    = in_s;
            second_n = MOST_NEG;
            cls_n    = '0;
        end else if (in_s > max_q) begin
            max_n    = in_s;
            second_n = max_q;
            cls_n    = cnt_q;
        end else if (in_s > second_q) begin
            second_n = in_s;
        end
    end
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        second_d     = second_q;
        cls_d        = cls_q;
        out_class_d  = out_class_q;
        out_max_d    = out_max_q;
        out_margin_d = out_margin_q;
        if (flush) begin
            state_d = COLLECT;
            cnt_d   = '0;
        end else if (state_q == HOLD) begin
            state_d = out_ready ? COLLECT : HOLD;
        end else if (in_valid) begin
            max_d    = max_n;
            second_d = second_n;
            cls_d    = cls_n;
            if (cnt_q == IDX_W'(NUM_CLASSES - 1)) begin
                cnt_d        = '0;
                state_d      = HOLD;
                out_class_d  = cls_n;
                out_max_d    = max_n;
                // Difference of two sign-extended values is never negative here and fits DATA_W+1 bits.
                out_margin_d = {max_n[DATA_W-1], max_n} - {second_n[DATA_W-1], second_n};
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            cnt_q        <= '0;
            max_q        <= '0;
            second_q     <= '0;
            cls_q        <= '0;
            out_class_q  <= '0;
            out_max_q    <= '0;
            out_margin_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            second_q     <= second_d;
            cls_q        <= cls_d;
            out_class_q  <= out_class_d;
            out_max_q    <= out_max_d;
            out_margin_q <= out_margin_d;
        end
    end
endmodule

// File: tb/tb_argmax_stream.sv
// tb_argmax_stream: directed self-checking bench for argmax_stream.
module tb_argmax_stream;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [17:0] in_data, out_max;
    logic [3:0]  out_class;
    logic [18:0] out_margin;
    int errors = 0;
    int checks = 0;
    int f1[10] = '{3, -5, 7, 2, 7, 1, 0, -1, 6, 4};
    int f2[10] = '{-131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072};
    int f3[10] = '{-10, -20, -30, -40, -50, -60, -70, -80, -90, -100};
    int fa[10] = '{0, 0, 0, 0, 0, 9, 0, 0, 0, 0};
    int fb[10] = '{-131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072, 131071};
    int fp[10] = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000};
    int f5[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int f7[10] = '{-1, -1, -1, 2, -1, -1, -1, -1, -1, -1};
    argmax_stream dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_max(out_max), .out_margin(out_margin)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Presents one beat and returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [17:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("send_timeout", 19'(in_ready), 19'd1);
        @(negedge clk);
    endtask
    task automatic send_frame(input int s[10], input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap)) @(negedge clk);
            end
            send(18'(s[i]));
        end
    endtask
    task automatic chk_res(input string tag, input logic [3:0] c, input logic [17:0] m, input logic [18:0] g);
        chk({tag, "_valid"}, 19'(out_valid), 19'd1);
        chk({tag, "_class"}, 19'(out_class), 19'(c));
        chk({tag, "_max"}, 19'(out_max), 19'(m));
        chk({tag, "_margin"}, out_margin, g);
    endtask
    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 19'(out_valid), 19'd0);
        chk("rst_ready", 19'(in_ready), 19'd1);
        chk("rst_class", 19'(out_class), 19'd0);
        chk("rst_max", 19'(out_max), 19'd0);
        chk("rst_margin", out_margin, 19'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // 1: tie at 7 goes to the lower index
        send_frame(f1, 9, 0);
        chk("t1_early", 19'(out_valid), 19'd0);
        send(18'(f1[9]));
        in_valid = 1'b0;
        chk_res("t1", 4'd2, 18'd7, 19'd0);
        chk("t1_bubble", 19'(in_ready), 19'd0);
        @(negedge clk);
        chk("t1_drop", 19'(out_valid), 19'd0);
        chk("t1_ready", 19'(in_ready), 19'd1);
        // 2: all most-negative
        send_frame(f2, 10, 0);
        in_valid = 1'b0;
        chk_res("t2", 4'd0, 18'h20000, 19'd0);
        @(negedge clk);
        // 3: gaps and consumer backpressure
        out_ready = 1'b0;
        send_frame(f3, 10, 3);
        in_valid = 1'b0;
        chk_res("t3", 4'd0, 18'h3FFF6, 19'd10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_res("t3_hold", 4'd0, 18'h3FFF6, 19'd10);
            chk("t3_hold_ready", 19'(in_ready), 19'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_drop", 19'(out_valid), 19'd0);
        // 4: back-to-back frames with in_valid held high
        send_frame(fa, 10, 0);
        chk_res("t4a", 4'd5, 18'd9, 19'd9);
        send_frame(fb, 10, 0);
        in_valid = 1'b0;
        chk_res("t4b", 4'd9, 18'h1FFFF, 19'h3FFFF);
        @(negedge clk);
        // 5: flush after four beats, flush beat itself dropped
        send_frame(fp, 4, 0);
        in_data = 18'd5000;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_flush_valid", 19'(out_valid), 19'd0);
        send_frame(f5, 10, 0);
        in_valid = 1'b0;
        chk_res("t5", 4'd7, 18'd1, 19'd1);
        @(negedge clk);
        chk("t5_single", 19'(out_valid), 19'd0);
        // 6: asynchronous reset mid-frame
        send_frame(fp, 5, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 19'(out_valid), 19'd0);
        chk("t6_rst_class", 19'(out_class), 19'd0);
        chk("t6_rst_max", 19'(out_max), 19'd0);
        chk("t6_rst_margin", out_margin, 19'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send_frame(f7, 10, 0);
        in_valid = 1'b0;
        chk_res("t6", 4'd3, 18'd2, 19'd3);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
